alu_op_dispatcher: RTL and testbench

Initiator side of the ALU unit interface. It accepts one operation at a time from an upstream valid/ready stream and decodes the 4-bit ALU_FUN into a one-hot unit enable plus a 2-bit sub-function. It drives the operands to the selected unit (arithmetic, logic, compare, shift), waits for that unit's flag and captures its output. It then returns the result on a downstream valid/ready stream. It sits between the instruction/command front end and the four ALU execution units.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_op_dispatcher_if.sv | 45 ++++
 rtl/alu_unit_decode.sv | 34 +++
 rtl/alu_op_dispatcher.sv | 129 ++++++++++++
 tb/tb_alu_op_dispatcher.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatcher slice: unit selects, logic sub-functions,
// dispatcher state encoding and the select-to-one-hot helper.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam logic [1:0] LOGIC_AND  = 2'b00;
  localparam logic [1:0] LOGIC_OR   = 2'b01;
  localparam logic [1:0] LOGIC_NAND = 2'b10;
  localparam logic [1:0] LOGIC_NOR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StResp  = 2'b11
  } state_e;

  function automatic logic [3:0] unit_onehot(logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/alu_op_dispatcher_if.sv
// Bundle of the dispatcher's upstream op stream, unit bus and downstream result stream.
// master is the dispatcher side; slave is the surrounding front end and execution units.
interface alu_op_dispatcher_if #(
  parameter int unsigned width = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] in_A;
  logic [width-1:0] in_B;
  logic [3:0]       in_fun;

  logic [width-1:0] unit_A;
  logic [width-1:0] unit_B;
  logic [1:0]       unit_fun;
  logic [3:0]       unit_en;
  logic [3:0]       unit_flag;
  logic [width-1:0] arith_out;
  logic [width-1:0] logic_out;
  logic [width-1:0] cmp_out;
  logic [width-1:0] shift_out;

  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] out_data;
  logic             out_err;

  modport master (
    input  in_valid, in_A, in_B, in_fun,
    input  unit_flag, arith_out, logic_out, cmp_out, shift_out,
    input  out_ready,
    output in_ready,
    output unit_A, unit_B, unit_fun, unit_en,
    output out_valid, out_data, out_err
  );

  modport slave (
    output in_valid, in_A, in_B, in_fun,
    output unit_flag, arith_out, logic_out, cmp_out, shift_out,
    output out_ready,
    input  in_ready,
    input  unit_A, unit_B, unit_fun, unit_en,
    input  out_valid, out_data, out_err
  );

endinterface

// File: rtl/alu_unit_decode.sv
// Combinational unit decode: select to one-hot enable (only while issuing), plus the
// selected unit's flag and result.
module alu_unit_decode
  import alu_pkg::*;
#(
  parameter int unsigned width = 16
) (
  input  logic [1:0]       sel,
  input  logic             issue,
  input  logic [3:0]       unit_flag,
  input  logic [width-1:0] arith_out,
  input  logic [width-1:0] logic_out,
  input  logic [width-1:0] cmp_out,
  input  logic [width-1:0] shift_out,
  output logic [3:0]       unit_en,
  output logic             flag_sel,
  output logic [width-1:0] result
);

  always_comb begin
    unit_en  = issue ? unit_onehot(sel) : 4'b0000;
    // Only the selected unit's flag matters; the others are masked out here.
    flag_sel = unit_flag[sel];
    result   = arith_out;
    unique case (sel)
      UNIT_ARITH: result = arith_out;
      UNIT_LOGIC: result = logic_out;
      UNIT_CMP:   result = cmp_out;
      UNIT_SHIFT: result = shift_out;
      default:    result = arith_out;
    endcase
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Initiator side of the ALU unit interface: accepts one op, issues it to the selected
// unit for one cycle, waits for that unit's flag (bounded by TIMEOUT) and returns the result.
module alu_op_dispatcher
  import alu_pkg::*;
#(
  parameter int unsigned width   = 16,
  parameter int unsigned TIMEOUT = 4
) (
  input logic                 clk,
  input logic                 rst,
  alu_op_dispatcher_if.master bus
);

  localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e state_q, state_d;

  logic [1:0]       sel_q;
  logic [1:0]       unit_fun_q;
  logic [width-1:0] unit_a_q;
  logic [width-1:0] unit_b_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic             accept;
  logic             issue;
  logic             waiting;
  logic             timed_out;
  logic             flag_sel;
  logic [width-1:0] result;
  logic [3:0]       unit_en;

  alu_unit_decode #(
    .width(width)
  ) u_decode (
    .sel       (sel_q),
    .issue     (issue),
    .unit_flag (bus.unit_flag),
    .arith_out (bus.arith_out),
    .logic_out (bus.logic_out),
    .cmp_out   (bus.cmp_out),
    .shift_out (bus.shift_out),
    .unit_en   (unit_en),
    .flag_sel  (flag_sel),
    .result    (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (flag_sel || timed_out) state_d = StResp;
      StResp:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pure state decode: in_ready has no path from out_ready.
  always_comb begin
    issue         = (state_q == StIssue);
    waiting       = (state_q == StWait);
    accept        = (state_q == StIdle) && bus.in_valid && !rst;
    bus.in_ready  = (state_q == StIdle) && !rst;
    bus.out_valid = (state_q == StResp);
  end

  assign timed_out = (cnt_q == CntLast);

  always_comb begin
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    if (issue) begin
      cnt_d = '0;
    end else if (waiting) begin
      if (flag_sel) begin
        out_data_d = result;
        out_err_d  = 1'b0;
      end else if (timed_out) begin
        out_data_d = '0;
        out_err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= UNIT_ARITH;
      unit_fun_q <= 2'b00;
      unit_a_q   <= '0;
      unit_b_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      // Operands stay held after issue until the next accept.
      if (accept) begin
        sel_q      <= bus.in_fun[3:2];
        unit_fun_q <= bus.in_fun[1:0];
        unit_a_q   <= bus.in_A;
        unit_b_q   <= bus.in_B;
      end
    end
  end

  assign bus.unit_A   = unit_a_q;
  assign bus.unit_B   = unit_b_q;
  assign bus.unit_fun = unit_fun_q;
  assign bus.unit_en  = unit_en;
  assign bus.out_data = out_data_q;
  assign bus.out_err  = out_err_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench for alu_op_dispatcher with behavioural unit models and a
// result-level reference (operation -> expected data/err) kept in queues.
module tb_alu_op_dispatcher;

  localparam int unsigned W  = 16;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_dispatcher_if #(.width(W)) bus ();

  alu_op_dispatcher #(
    .width   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] respond_mask;
  logic [3:0] manual_flag;
  logic [3:0] flag_q;

  function automatic logic [W-1:0] unit_result(logic [1:0] sel, logic [1:0] f,
                                                logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] r;
    logic [3:0]   sh;
    sh = b[3:0];
    r  = '0;
    case (sel)
      2'd0: case (f)
        2'd0: r = a + b;
        2'd1: r = a - b;
        2'd2: r = b - a;
        default: r = a + b + 1;
      endcase
      2'd1: case (f)
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = ~(a & b);
        default: r = ~(a | b);
      endcase
      2'd2: case (f)
        2'd0: r = {{(W-1){1'b0}}, a == b};
        2'd1: r = {{(W-1){1'b0}}, a < b};
        2'd2: r = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
        default: r = {{(W-1){1'b0}}, a != b};
      endcase
      default: case (f)
        2'd0: r = a << sh;
        2'd1: r = a >> sh;
        2'd2: r = $signed(a) >>> sh;
        default: r = (a << sh) | (a >> (W - sh));
      endcase
    endcase
    return r;
  endfunction

  // {err, data} the dispatcher must return for an op, given which units respond.
  function automatic logic [W:0] expect_of(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] f,
                                           logic [3:0] mask);
    if (mask[f[3:2]]) return {1'b0, unit_result(f[3:2], f[1:0], a, b)};
    return {1'b1, {W{1'b0}}};
  endfunction

  // Unit models: results follow the held operands, flag one cycle after enable.
  assign bus.arith_out = unit_result(2'd0, bus.unit_fun, bus.unit_A, bus.unit_B);
  assign bus.logic_out = unit_result(2'd1, bus.unit_fun, bus.unit_A, bus.unit_B);
  assign bus.cmp_out   = unit_result(2'd2, bus.unit_fun, bus.unit_A, bus.unit_B);
  assign bus.shift_out = unit_result(2'd3, bus.unit_fun, bus.unit_A, bus.unit_B);

  always @(posedge clk) begin
    if (rst) flag_q <= 4'b0000;
    else     flag_q <= bus.unit_en & respond_mask;
  end
  assign bus.unit_flag = flag_q | manual_flag;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                         output bit ok);
    int n = 0;
    bus.in_A     = a;
    bus.in_B     = b;
    bus.in_fun   = f;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(output logic [W-1:0] data, output logic err, output int lat,
                         output bit ok);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    ok   = bus.out_valid;
    data = bus.out_data;
    err  = bus.out_err;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.unit_en !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b valid=%b err=%b exp en=0000 valid=0 err=0",
               bus.unit_en, bus.out_valid, bus.out_err);
    end
    checks++;
    if (bus.out_data !== '0 || bus.unit_A !== '0 || bus.unit_B !== '0 ||
        bus.unit_fun !== 2'b0) begin
      failures++;
      $display("FAIL reset_data got data=%h A=%h B=%h fun=%b exp all zero",
               bus.out_data, bus.unit_A, bus.unit_B, bus.unit_fun);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_logic_and();
    bus.in_A = 16'hF0F0; bus.in_B = 16'h0FF0; bus.in_fun = 4'b0100; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.unit_en !== 4'b0010 || bus.unit_A !== 16'hF0F0 || bus.unit_fun !== 2'b00) begin
      failures++;
      $display("FAIL and_issue got en=%b A=%h fun=%b exp en=0010 A=f0f0 fun=00",
               bus.unit_en, bus.unit_A, bus.unit_fun);
    end
    tick();
    checks++;
    if (bus.unit_en !== 4'b0000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL and_wait got en=%b valid=%b exp en=0000 valid=0", bus.unit_en,
               bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h00F0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL and_result got valid=%b data=%h err=%b exp valid=1 data=00f0 err=0",
               bus.out_valid, bus.out_data, bus.out_err);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL and_done got valid=%b in_ready=%b exp valid=0 in_ready=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, exp;
    bit ok;
    int n = 0;
    a = W'($urandom); b = W'($urandom);
    exp = ~(a | b);
    send_op(a, b, 4'b0111, ok);
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    bus.in_A = ~a; bus.in_fun = 4'b0000; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h in_ready=%b exp valid=1 data=%h in_ready=0",
                 i, bus.out_valid, bus.out_data, bus.in_ready, exp);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got valid=%b in_ready=%b exp valid=0 in_ready=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] a, b, data;
    logic [W:0]   exp;
    logic         err;
    int           lat;
    bit           ok1, ok2;
    respond_mask = 4'b1011;
    a = W'($urandom); b = W'($urandom);
    send_op(a, b, 4'b1000, ok1);
    collect(data, err, lat, ok2);
    checks++;
    if (!ok1 || !ok2 || err !== 1'b1 || data !== '0 || lat != int'(TO) + 2) begin
      failures++;
      $display("FAIL timeout got ok=%b%b err=%b data=%h lat=%0d exp err=1 data=0000 lat=%0d",
               ok1, ok2, err, data, lat, TO + 2);
    end
    respond_mask = 4'b1111;
    a = W'($urandom); b = W'($urandom);
    exp = expect_of(a, b, 4'b1001, respond_mask);
    send_op(a, b, 4'b1001, ok1);
    collect(data, err, lat, ok2);
    checks++;
    if (!ok1 || !ok2 || {err, data} !== exp || lat != 3) begin
      failures++;
      $display("FAIL after_timeout got ok=%b%b err=%b data=%h lat=%0d exp err=%b data=%h lat=3",
               ok1, ok2, err, data, lat, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_wrong_unit();
    bit ok;
    respond_mask = 4'b0000;
    manual_flag  = 4'b0001;
    send_op(16'h1234, 16'h00FF, 4'b0101, ok);
    tick();
    tick();
    checks++;
    if (!ok || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrong_flag_capture got valid=%b ok=%b exp valid=0 ok=1", bus.out_valid, ok);
    end
    manual_flag = 4'b0010;
    tick();
    manual_flag = 4'b0000;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h12FF || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL right_flag_capture got valid=%b data=%h err=%b exp valid=1 data=12ff err=0",
               bus.out_valid, bus.out_data, bus.out_err);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    respond_mask = 4'b1111;
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    int stale = 0;
    respond_mask = 4'b0000;
    send_op(W'($urandom), W'($urandom), 4'b1110, ok);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (!ok || bus.unit_en !== 4'b0 || bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got en=%b valid=%b err=%b ok=%b exp en=0000 valid=0 err=0 ok=1",
               bus.unit_en, bus.out_valid, bus.out_err, ok);
    end
    rst = 1'b0;
    respond_mask = 4'b1111;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL midop_idle got in_ready=%b exp=1", bus.in_ready);
    end
    for (int i = 0; i < int'(TO) + 3; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL midop_stale got valid_cycles=%0d exp=0", stale);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] opa[2], opb[2];
    logic [3:0]   opf[2];
    logic [W:0]   exp_q[$];
    logic [W:0]   exp;
    int acc_cyc[2], hs_cyc[2];
    int sent = 0, recv = 0;
    for (int i = 0; i < 2; i++) begin
      opa[i] = W'($urandom); opb[i] = W'($urandom); opf[i] = 4'($urandom);
    end
    bus.out_ready = 1'b1;
    bus.in_A = opa[0]; bus.in_B = opb[0]; bus.in_fun = opf[0]; bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && recv < 2; cyc++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(expect_of(opa[sent], opb[sent], opf[sent], respond_mask));
        acc_cyc[sent] = cyc;
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, {W{1'b1}}};
        checks++;
        if ({bus.out_err, bus.out_data} !== exp) begin
          failures++;
          $display("FAIL b2b_data[%0d] got err=%b data=%h exp err=%b data=%h", recv,
                   bus.out_err, bus.out_data, exp[W], exp[W-1:0]);
        end
        hs_cyc[recv] = cyc;
        recv++;
      end
      tick();
      if (sent < 2) begin
        bus.in_A = opa[sent]; bus.in_B = opb[sent]; bus.in_fun = opf[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (recv != 2) begin
      failures++; $display("FAIL b2b_count got=%0d exp=2", recv);
    end else begin
      checks++;
      if (acc_cyc[1] != hs_cyc[0] + 1 || acc_cyc[1] - acc_cyc[0] != 4) begin
        failures++;
        $display("FAIL b2b_spacing got acc0=%0d hs0=%0d acc1=%0d exp acc1=hs0+1=acc0+4",
                 acc_cyc[0], hs_cyc[0], acc_cyc[1]);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 24;
    logic [W:0] exp_q[$];
    logic [W:0] exp;
    int sent = 0, recv = 0, bad = 0;
    logic [W-1:0] a, b;
    logic [3:0]   f;
    a = W'($urandom); b = W'($urandom); f = 4'($urandom);
    bus.in_A = a; bus.in_B = b; bus.in_fun = f; bus.in_valid = 1'b1;
    bus.out_ready = 1'($urandom);
    for (int cyc = 0; cyc < 2000 && recv < N; cyc++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(expect_of(bus.in_A, bus.in_B, bus.in_fun, respond_mask));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, {W{1'b1}}};
        if ({bus.out_err, bus.out_data} !== exp) begin
          bad++;
          $display("FAIL rand_data[%0d] got err=%b data=%h exp err=%b data=%h", recv,
                   bus.out_err, bus.out_data, exp[W], exp[W-1:0]);
        end
        recv++;
      end
      tick();
      bus.out_ready = 1'($urandom);
      if (sent < N) begin
        bus.in_A = W'($urandom); bus.in_B = W'($urandom); bus.in_fun = 4'($urandom);
        bus.in_valid = 1'($urandom_range(0, 3) != 0);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bad != 0) failures++;
    checks++;
    if (recv != N) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", recv, N);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    respond_mask  = 4'b1111;
    manual_flag   = 4'b0000;
    bus.in_valid  = 1'b0;
    bus.in_A      = '0;
    bus.in_B      = '0;
    bus.in_fun    = 4'b0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_logic_and();
    test_backpressure();
    test_timeout();
    test_wrong_unit();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
